csa_multichannel_accumulator: RTL and testbench

Multi-channel carry-save accumulator with a pipelined, back-pressured read-out path. Each of `CHANNELS` independent channels holds its running total in redundant (sum, carry) form, so an accumulate is one 3:2 compression per cycle with no carry propagation. A read request snapshots one channel and resolves it to binary through a registered full adder. The read can optionally clear the channel. The block sits between a sample/partial-product source and a consumer that drains results at its own pace.

---
 rtl/csa_multichannel_accumulator_if.sv | 33 +++
 rtl/csa_multichannel_accumulator.sv | 120 ++++++++++++
 tb/tb_csa_multichannel_accumulator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/csa_multichannel_accumulator_if.sv
// Handshake bundle for the carry-save multichannel accumulator:
// accumulate port, read-request port and back-pressured result port.
interface csa_multichannel_accumulator_if #(
    parameter int N        = 16,
    parameter int CHANNELS = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic          in_valid;
    logic [CW-1:0] in_channel;
    logic [N-1:0]  in;
    logic          rd_valid;
    logic [CW-1:0] rd_channel;
    logic          rd_clear;
    logic          rd_ready;
    logic          out_valid;
    logic [CW-1:0] out_channel;
    logic [N-1:0]  out;
    logic          out_ready;

    modport master (
        output in_valid, in_channel, in,
        output rd_valid, rd_channel, rd_clear,
        output out_ready,
        input  rd_ready, out_valid, out_channel, out
    );

    modport slave (
        input  in_valid, in_channel, in,
        input  rd_valid, rd_channel, rd_clear,
        input  out_ready,
        output rd_ready, out_valid, out_channel, out
    );
endinterface

// File: rtl/csa_multichannel_accumulator.sv
// Per-channel carry-save accumulators with a two-stage snapshot/resolve
// read-out pipeline (stage A holds u/v, stage B holds the binary sum).
module csa_multichannel_accumulator #(
    parameter int N        = 16,
    parameter int CHANNELS = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic clock,
    input  logic reset,
    csa_multichannel_accumulator_if.slave bus
);
    logic [N-1:0]  r_u [CHANNELS];
    logic [N-1:0]  r_v [CHANNELS];
    logic [N-1:0]  w_u_nxt [CHANNELS];
    logic [N-1:0]  w_v_nxt [CHANNELS];
    logic [N-1:0]  w_maj [CHANNELS];

    logic          r_a_valid;
    logic [N-1:0]  r_a_u;
    logic [N-1:0]  r_a_v;
    logic [CW-1:0] r_a_ch;

    logic          r_out_valid;
    logic [N-1:0]  r_out;
    logic [CW-1:0] r_out_ch;

    logic          w_b_adv;
    logic          w_a_load;
    logic          w_rd_fire;
    logic [N-1:0]  w_snap_u;
    logic [N-1:0]  w_snap_v;

    assign w_b_adv   = !r_out_valid || bus.out_ready;
    assign w_a_load  = !r_a_valid || w_b_adv;
    assign w_rd_fire = bus.rd_valid && w_a_load;

    assign bus.rd_ready    = w_a_load;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_channel = r_out_ch;
    assign bus.out         = r_out;

    // Out-of-range channels match no entry, so they snapshot as zero.
    always_comb begin
        w_snap_u = '0;
        w_snap_v = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.rd_channel == CW'(c)) begin
                w_snap_u = r_u[c];
                w_snap_v = r_v[c];
            end
        end
    end

    // A clear colliding with an accumulate leaves only the new addend.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            logic acc;
            logic clr;
            acc = bus.in_valid && (bus.in_channel == CW'(c));
            clr = w_rd_fire && bus.rd_clear
                  && (bus.rd_channel == CW'(c));
            w_maj[c] = (bus.in & r_u[c]) | (bus.in & r_v[c])
                     | (r_u[c] & r_v[c]);
            w_u_nxt[c] = r_u[c];
            w_v_nxt[c] = r_v[c];
            if (clr && acc) begin
                w_u_nxt[c] = bus.in;
                w_v_nxt[c] = '0;
            end else if (clr) begin
                w_u_nxt[c] = '0;
                w_v_nxt[c] = '0;
            end else if (acc) begin
                w_u_nxt[c] = bus.in ^ r_u[c] ^ r_v[c];
                w_v_nxt[c] = {w_maj[c][N-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (reset) begin
                r_u[c] <= '0;
                r_v[c] <= '0;
            end else begin
                r_u[c] <= w_u_nxt[c];
                r_v[c] <= w_v_nxt[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_valid <= 1'b0;
            r_a_u     <= '0;
            r_a_v     <= '0;
            r_a_ch    <= '0;
        end else if (w_a_load) begin
            r_a_valid <= bus.rd_valid;
            if (bus.rd_valid) begin
                r_a_u  <= w_snap_u;
                r_a_v  <= w_snap_v;
                r_a_ch <= bus.rd_channel;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_ch    <= '0;
        end else if (w_b_adv) begin
            r_out_valid <= r_a_valid;
            if (r_a_valid) begin
                r_out    <= r_a_u + r_a_v;
                r_out_ch <= r_a_ch;
            end
        end
    end
endmodule

// File: tb/tb_csa_multichannel_accumulator.sv
// Directed and short randomised checks of the carry-save accumulator.
module tb_csa_multichannel_accumulator;
    localparam int N  = 16;
    localparam int CH = 4;
    localparam int CW = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    csa_multichannel_accumulator_if #(.N(N), .CHANNELS(CH), .CW(CW)) bus ();

    csa_multichannel_accumulator #(.N(N), .CHANNELS(CH), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_channel = '0;
        bus.in         = '0;
        bus.rd_valid   = 1'b0;
        bus.rd_channel = '0;
        bus.rd_clear   = 1'b0;
    endtask

    task automatic acc(input int ch, input logic [N-1:0] val);
        bus.in_valid   = 1'b1;
        bus.in_channel = CW'(ch);
        bus.in         = val;
        cyc();
        bus.in_valid   = 1'b0;
    endtask

    logic [N-1:0]    model [CH];
    logic [CW+N-1:0] q [$];
    logic            fire;
    logic            hs;

    initial begin
        idle();
        bus.out_ready = 1'b1;

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_rd_ready", bus.rd_ready, 1);
        chk("rst_out", bus.out, 0);
        chk("rst_out_ch", bus.out_channel, 0);

        // wrap: 0xFFFF + 0x0002 = 0x0001
        acc(0, 16'hFFFF);
        acc(0, 16'h0002);
        bus.rd_valid   = 1'b1;
        bus.rd_channel = 2'd0;
        bus.rd_clear   = 1'b1;
        #1;
        chk("wrap_rd_ready", bus.rd_ready, 1);
        cyc();
        idle();
        chk("wrap_lat1", bus.out_valid, 0);
        cyc();
        chk("wrap_valid", bus.out_valid, 1);
        chk("wrap_out", bus.out, 16'h0001);
        chk("wrap_ch", bus.out_channel, 0);
        cyc();
        chk("wrap_drop", bus.out_valid, 0);

        // channel independence, back-to-back reads
        acc(0, 16'd5);
        acc(0, 16'd7);
        acc(3, 16'd100);
        bus.rd_valid   = 1'b1;
        bus.rd_channel = 2'd0;
        cyc();
        bus.rd_channel = 2'd3;
        cyc();
        idle();
        chk("ind_out0", bus.out, 16'd12);
        chk("ind_ch0", bus.out_channel, 0);
        cyc();
        chk("ind_valid1", bus.out_valid, 1);
        chk("ind_out1", bus.out, 16'd100);
        chk("ind_ch1", bus.out_channel, 3);
        cyc();

        // read-clear colliding with accumulate
        acc(1, 16'd10);
        bus.in_valid   = 1'b1;
        bus.in_channel = 2'd1;
        bus.in         = 16'd3;
        bus.rd_valid   = 1'b1;
        bus.rd_channel = 2'd1;
        bus.rd_clear   = 1'b1;
        cyc();
        idle();
        cyc();
        chk("coll_snap", bus.out, 16'd10);
        bus.rd_valid   = 1'b1;
        bus.rd_channel = 2'd1;
        cyc();
        idle();
        cyc();
        chk("coll_after", bus.out, 16'd3);
        chk("coll_ch", bus.out_channel, 1);
        cyc();

        // back-pressure: two reads buffered, third stalls
        bus.out_ready  = 1'b0;
        bus.rd_valid   = 1'b1;
        bus.rd_channel = 2'd3;
        cyc();
        bus.rd_channel = 2'd0;
        #1;
        chk("bp_rdy2", bus.rd_ready, 1);
        cyc();
        bus.rd_channel = 2'd1;
        #1;
        chk("bp_rdy3", bus.rd_ready, 0);
        cyc();
        chk("bp_hold_v", bus.out_valid, 1);
        chk("bp_hold_out", bus.out, 16'd100);
        cyc();
        chk("bp_stable", bus.out, 16'd100);
        chk("bp_stable_ch", bus.out_channel, 3);
        idle();
        bus.out_ready = 1'b1;
        cyc();
        chk("bp_next_v", bus.out_valid, 1);
        chk("bp_next", bus.out, 16'd12);
        chk("bp_next_ch", bus.out_channel, 0);
        cyc();
        chk("bp_empty", bus.out_valid, 0);

        // reset with a read in flight
        acc(2, 16'd9);
        bus.rd_valid   = 1'b1;
        bus.rd_channel = 2'd2;
        cyc();
        idle();
        reset = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_channel = 2'd2;
        bus.in         = 16'd4;
        cyc();
        reset = 1'b0;
        idle();
        chk("mr_v0", bus.out_valid, 0);
        cyc();
        chk("mr_v1", bus.out_valid, 0);
        for (int i = 0; i < CH; i++) begin
            bus.rd_valid   = 1'b1;
            bus.rd_channel = CW'(i);
            cyc();
            idle();
            cyc();
            chk("mr_zero", bus.out, 0);
            chk("mr_ch", bus.out_channel, i);
            cyc();
        end

        // randomised soak against a modulo-2^N model
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int c = 0; c < CH; c++) model[c] = '0;
        q.delete();
        for (int k = 0; k < 400; k++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_channel = CW'($urandom_range(0, CH - 1));
            bus.in         = N'($urandom);
            bus.rd_valid   = 1'($urandom_range(0, 2) == 0);
            bus.rd_channel = CW'($urandom_range(0, CH - 1));
            bus.rd_clear   = 1'($urandom_range(0, 3) == 0);
            bus.out_ready  = 1'($urandom_range(0, 3) != 0);
            #1;
            fire = bus.rd_valid && bus.rd_ready;
            hs   = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (q.size() == 0) chk("soak_spurious", q.size(), 1);
                else chk("soak_out", {bus.out_channel, bus.out},
                         q.pop_front());
            end
            if (fire) begin
                q.push_back({bus.rd_channel, model[bus.rd_channel]});
                if (bus.rd_clear) model[bus.rd_channel] = '0;
            end
            if (bus.in_valid) begin
                if (fire && bus.rd_clear
                    && bus.rd_channel == bus.in_channel)
                    model[bus.in_channel] = bus.in;
                else
                    model[bus.in_channel] = model[bus.in_channel] + bus.in;
            end
            cyc();
        end
        idle();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            if (bus.out_valid)
                chk("drain_out", {bus.out_channel, bus.out}, q.pop_front());
            cyc();
        end
        chk("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
